// File: rtl/spike_collector.sv
// spike_collector
//   Clocked sink for the last neuron layer. Each request line is synchronised and
//   acknowledged with a 4-phase handshake. While the counting window is open, every
//   new request increments a saturating per-neuron counter. When the window closes,
//   the counters are scanned in order and the index of the largest one is reported.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   req_in       asynchronous 4-phase spike requests, one per neuron
//   ack_in       registered acknowledges back to the layer
//   start        pulse: clear counters and open the counting window (aborts a window or scan)
//   stop         pulse: close the window and start the argmax scan
//   busy         high while counting or scanning
//   done         one-cycle pulse when class_out is updated
//   class_valid  high from done until the next start or rst
//   class_out    winning neuron index (lowest index on ties)
//   overflow     sticky: a counter saturated in the current window
//   rd_idx       counter readout select
//   rd_count     count[rd_idx]; out-of-range indices read 0
//
// Top FSM
//   state | meaning
//   IDLE  | window closed; spikes are acknowledged but not counted
//   COUNT | window open; new spikes increment their counters
//   SCAN  | stepping scan_idx over the counters, tracking the running maximum
//
// Channel FSM (one per neuron, state bit drives ack_in directly)
//   state    | meaning
//   WAIT_REQ | ack low, waiting for the synchronised request to rise
//   WAIT_REL | ack high, waiting for the synchronised request to fall

module spike_collector #(
  parameter int neurons     = 8,
  parameter int cnt_bits    = 8,
  parameter int sync_stages = 2,
  localparam int idx_bits   = $clog2(neurons)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [neurons-1:0]  req_in,
  output logic [neurons-1:0]  ack_in,
  input  logic                start,
  input  logic                stop,
  output logic                busy,
  output logic                done,
  output logic                class_valid,
  output logic [idx_bits-1:0] class_out,
  output logic                overflow,
  input  logic [idx_bits-1:0] rd_idx,
  output logic [cnt_bits-1:0] rd_count
);

  typedef enum logic [1:0] {IDLE, COUNT, SCAN} top_state_t;
  typedef enum logic {WAIT_REQ = 1'b0, WAIT_REL = 1'b1} ch_state_t;

  localparam logic [cnt_bits-1:0] cnt_max  = '1;
  localparam logic [idx_bits-1:0] last_idx = idx_bits'(neurons - 1);

  logic [neurons-1:0]  sync_q [sync_stages];
  logic [neurons-1:0]  rs;
  ch_state_t           ch_state [neurons];
  ch_state_t           ch_next  [neurons];
  logic [neurons-1:0]  inc;

  top_state_t          state, state_next;
  logic                clear, load_scan, finish, counting;

  logic [cnt_bits-1:0] count [neurons];
  logic [cnt_bits-1:0] best;
  logic [idx_bits-1:0] best_idx;
  logic [idx_bits-1:0] scan_idx;
  logic [cnt_bits-1:0] scan_val;
  logic                greater;
  logic [idx_bits-1:0] win_idx;

  // request synchronisers; reset so a request held across reset is seen as new
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < sync_stages; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= req_in;
      for (int s = 1; s < sync_stages; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign rs = sync_q[sync_stages-1];

  // per-channel handshake FSMs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < neurons; i++) ch_state[i] <= WAIT_REQ;
    end else begin
      for (int i = 0; i < neurons; i++) ch_state[i] <= ch_next[i];
    end
  end

  // a clearing start takes precedence over a same-cycle increment
  assign counting = (state == COUNT) && !start;

  always_comb begin
    ack_in = '0;
    inc    = '0;
    for (int i = 0; i < neurons; i++) begin
      ch_next[i] = ch_state[i];
      ack_in[i]  = (ch_state[i] == WAIT_REL);
      case (ch_state[i])
        WAIT_REQ: begin
          if (rs[i]) begin
            ch_next[i] = WAIT_REL;
            inc[i]     = counting;
          end
        end
        WAIT_REL: begin
          if (!rs[i]) ch_next[i] = WAIT_REQ;
        end
        default: ch_next[i] = WAIT_REQ;
      endcase
    end
  end

  // top FSM
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    clear      = 1'b0;
    load_scan  = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear      = 1'b1;
          state_next = COUNT;
        end
      end
      COUNT: begin
        if (start) begin
          clear = 1'b1;
        end else if (stop) begin
          if (neurons == 1) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else begin
            load_scan  = 1'b1;
            state_next = SCAN;
          end
        end
      end
      SCAN: begin
        if (start) begin
          clear      = 1'b1;
          state_next = COUNT;
        end else if (scan_idx == last_idx) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // saturating counters
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < neurons; i++) count[i] <= '0;
      overflow <= 1'b0;
    end else begin
      for (int i = 0; i < neurons; i++) begin
        if (inc[i]) begin
          if (count[i] == cnt_max) overflow <= 1'b1;
          else                     count[i] <= count[i] + cnt_bits'(1);
        end
      end
    end
  end

  // argmax scan; strict compare keeps the lowest index on ties
  assign scan_val = count[scan_idx];
  assign greater  = (scan_val > best);
  assign win_idx  = ((state == SCAN) && greater) ? scan_idx : best_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      best        <= '0;
      best_idx    <= '0;
      scan_idx    <= '0;
      class_out   <= '0;
      class_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= finish;
      if (load_scan) begin
        best     <= count[0];
        best_idx <= '0;
        scan_idx <= idx_bits'(1);
      end else if (state == SCAN) begin
        if (greater) begin
          best     <= scan_val;
          best_idx <= scan_idx;
        end
        scan_idx <= scan_idx + idx_bits'(1);
      end
      if (finish) begin
        class_out   <= win_idx;
        class_valid <= 1'b1;
      end
      if (clear) class_valid <= 1'b0;
    end
  end

  always_comb begin
    rd_count = '0;
    if ({1'b0, rd_idx} < (idx_bits + 1)'(neurons)) rd_count = count[rd_idx];
  end

endmodule

// File: tb/tb_spike_collector.sv
module tb_spike_collector;

  localparam int S_ACK   = 0;
  localparam int S_CNT   = 1;
  localparam int S_BUSY  = 2;
  localparam int S_CV    = 3;
  localparam int S_OVF   = 4;
  localparam int S_CLS   = 5;
  localparam int S_CNT4  = 6;
  localparam int S_OVF4  = 7;
  localparam int S_ACKM  = 8;
  localparam int S_PEND  = 9;
  localparam int S_ACK4  = 10;
  localparam int S_CLS4  = 11;
  localparam int S_CV4   = 12;
  localparam int S_BUSY4 = 13;

  typedef struct {
    string name;
    int    sel;
    int    exp;
    int    mask;
  } chk_t;

  typedef struct {
    int cls;
    int cyc;
  } dexp_t;

  logic       clk;
  logic       rst;
  logic [7:0] req_in;
  logic       start;
  logic       stop;
  logic [2:0] rd_idx;

  logic [7:0] ack_in, ack_in4;
  logic       busy, busy4, done, done4, class_valid, class_valid4, overflow, overflow4;
  logic [2:0] class_out, class_out4;
  logic [7:0] rd_count;
  logic [3:0] rd_count4;

  chk_t  chk_q [$];
  dexp_t class_q [$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  chk_t        c;
  dexp_t       d;
  logic [31:0] act;

  spike_collector #(.neurons(8), .cnt_bits(8), .sync_stages(2)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .ack_in(ack_in),
    .start(start), .stop(stop), .busy(busy), .done(done),
    .class_valid(class_valid), .class_out(class_out), .overflow(overflow),
    .rd_idx(rd_idx), .rd_count(rd_count)
  );

  spike_collector #(.neurons(8), .cnt_bits(4), .sync_stages(2)) dut4 (
    .clk(clk), .rst(rst), .req_in(req_in), .ack_in(ack_in4),
    .start(start), .stop(stop), .busy(busy4), .done(done4),
    .class_valid(class_valid4), .class_out(class_out4), .overflow(overflow4),
    .rd_idx(rd_idx), .rd_count(rd_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: drains pending expectations and checks every done pulse
  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      case (c.sel)
        S_ACK:   act = 32'(ack_in);
        S_CNT:   act = 32'(rd_count);
        S_BUSY:  act = 32'(busy);
        S_CV:    act = 32'(class_valid);
        S_OVF:   act = 32'(overflow);
        S_CLS:   act = 32'(class_out);
        S_CNT4:  act = 32'(rd_count4);
        S_OVF4:  act = 32'(overflow4);
        S_ACKM:  act = 32'(ack_in & 8'(c.mask));
        S_PEND:  act = 32'(class_q.size());
        S_ACK4:  act = 32'(ack_in4);
        S_CLS4:  act = 32'(class_out4);
        S_CV4:   act = 32'(class_valid4);
        S_BUSY4: act = 32'(busy4);
        default: act = 32'hDEAD_BEEF;
      endcase
      checks++;
      if (act !== 32'(c.exp)) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", c.name, act, c.exp, cyc);
      end
    end
    if (done || done4) begin
      checks++;
      if (done4 !== done) begin
        errors++;
        $display("FAIL done_pair: got done4=%0b expected %0b (cycle %0d)", done4, done, cyc);
      end
    end
    if (done) begin
      if (class_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
      end else begin
        d = class_q.pop_front();
        checks += 2;
        if (32'(class_out) !== 32'(d.cls)) begin
          errors++;
          $display("FAIL class_out: got %0d expected %0d", class_out, d.cls);
        end
        if (cyc != d.cyc) begin
          errors++;
          $display("FAIL done_cycle: got %0d expected %0d", cyc, d.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_chk(input string name, input int sel, input int exp, input int mask = 0);
    chk_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    e.mask = mask;
    chk_q.push_back(e);
  endtask

  task automatic push_done(input int cls, input int at);
    dexp_t e;
    e.cls = cls;
    e.cyc = at;
    class_q.push_back(e);
  endtask

  task automatic check_count(input int idx, input int exp);
    rd_idx = 3'(idx);
    push_chk($sformatf("count[%0d]", idx), S_CNT, exp);
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // one full 4-phase handshake on the channels in m, bounded waits
  task automatic spike(input logic [7:0] m);
    req_in = req_in | m;
    for (int n = 0; n < 20 && (ack_in & m) != m; n++) tick();
    if ((ack_in & m) != m) push_chk("ack_rise_timeout", S_ACKM, int'(m), int'(m));
    req_in = req_in & ~m;
    for (int n = 0; n < 20 && (ack_in & m) != 8'h00; n++) tick();
    if ((ack_in & m) != 8'h00) push_chk("ack_fall_timeout", S_ACKM, 0, int'(m));
  endtask

  initial begin
    rst    = 1'b1;
    req_in = 8'hFF;
    start  = 1'b0;
    stop   = 1'b0;
    rd_idx = 3'd0;

    // reset with all requests high
    repeat (3) tick();
    push_chk("rst_ack", S_ACK, 8'h00);
    push_chk("rst_busy", S_BUSY, 0);
    push_chk("rst_class_valid", S_CV, 0);
    push_chk("rst_class_out", S_CLS, 0);
    push_chk("rst_overflow", S_OVF, 0);
    rst = 1'b0;
    tick();
    tick();
    push_chk("rel_ack_edge2", S_ACK, 8'h00);
    tick();
    push_chk("rel_ack_edge3", S_ACK, 8'hFF);
    push_chk("rel_ack4_edge3", S_ACK4, 8'hFF);
    req_in = 8'h00;
    tick();
    tick();
    push_chk("fall_ack_edge2", S_ACK, 8'hFF);
    tick();
    push_chk("fall_ack_edge3", S_ACK, 8'h00);
    for (int i = 0; i < 8; i++) check_count(i, 0);

    // single spike latency on channel 3
    pulse_start();
    req_in = 8'h08;
    tick();
    tick();
    push_chk("lat_rise_edge2", S_ACK, 8'h00);
    tick();
    push_chk("lat_rise_edge3", S_ACK, 8'h08);
    req_in = 8'h00;
    tick();
    tick();
    push_chk("lat_fall_edge2", S_ACK, 8'h08);
    tick();
    push_chk("lat_fall_edge3", S_ACK, 8'h00);
    check_count(3, 1);

    // classification: ch2=5+1, ch5=7, ch6=7, ch1=1 -> tie to class 5
    pulse_start();
    repeat (5) spike(8'h04);
    repeat (7) spike(8'h20);
    repeat (7) spike(8'h40);
    spike(8'h06);
    check_count(0, 0);
    check_count(1, 1);
    check_count(2, 6);
    check_count(3, 0);
    check_count(5, 7);
    check_count(6, 7);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    push_done(5, cyc + 7);
    push_chk("scan_busy", S_BUSY, 1);
    repeat (9) tick();
    push_chk("cls_valid", S_CV, 1);
    push_chk("cls_idle_busy", S_BUSY, 0);
    push_chk("cls4_out", S_CLS4, 5);
    push_chk("cls4_valid", S_CV4, 1);
    check_count(2, 6);

    // spikes in IDLE are acknowledged but not counted
    spike(8'h01);
    spike(8'h01);
    check_count(0, 0);
    check_count(5, 7);

    // spikes during SCAN are not counted
    pulse_start();
    spike(8'h10);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    push_done(4, cyc + 7);
    spike(8'h10);
    repeat (3) tick();
    check_count(4, 1);
    push_chk("gate_valid", S_CV, 1);

    // saturation: 17 spikes on ch0
    pulse_start();
    push_chk("sat_start_clears_valid", S_CV, 0);
    repeat (17) spike(8'h01);
    rd_idx = 3'd0;
    push_chk("sat_count8", S_CNT, 17);
    push_chk("sat_count4", S_CNT4, 15);
    push_chk("sat_ovf8", S_OVF, 0);
    push_chk("sat_ovf4", S_OVF4, 1);
    tick();
    pulse_start();
    push_chk("sat_ovf4_cleared", S_OVF4, 0);
    push_chk("sat_count4_cleared", S_CNT4, 0);
    push_chk("sat_count8_cleared", S_CNT, 0);

    // start together with stop: start wins, window stays open
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    push_chk("ss_busy", S_BUSY, 1);
    repeat (10) tick();
    push_chk("ss_still_busy", S_BUSY, 1);
    push_chk("ss_still_busy4", S_BUSY4, 1);

    // start during SCAN aborts without done
    spike(8'h80);
    check_count(7, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    tick();
    pulse_start();
    rd_idx = 3'd7;
    push_chk("abort_busy", S_BUSY, 1);
    push_chk("abort_count7", S_CNT, 0);
    repeat (10) tick();
    push_chk("abort_valid", S_CV, 0);
    push_chk("abort_class_held", S_CLS, 4);
    push_chk("abort_still_counting", S_BUSY, 1);

    // reset in the middle of a handshake
    req_in = 8'h02;
    for (int n = 0; n < 20 && ack_in[1] != 1'b1; n++) tick();
    push_chk("mid_ack_up", S_ACK, 8'h02);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push_chk("mid_rst_ack", S_ACK, 8'h00);
    push_chk("mid_rst_class", S_CLS, 0);
    push_chk("mid_rst_busy", S_BUSY, 0);
    tick();
    tick();
    push_chk("mid_reack_edge2", S_ACK, 8'h00);
    tick();
    push_chk("mid_reack_edge3", S_ACK, 8'h02);
    req_in = 8'h00;
    repeat (4) tick();
    push_chk("mid_release", S_ACK, 8'h00);
    check_count(1, 0);

    push_chk("pending_done", S_PEND, 0);
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
